// File: rtl/div_pkg.sv
// Shared constants for the lab datapath divider: default width, FSM encoding
// and the quotient reported for a zero divisor.
package div_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_t;

    localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/seq_div_8_sub_n.sv
// W-bit ripple borrow-chain subtractor: {Bout,Diff} = A - B - Bin.
// Each bit is a full subtractor, so the borrow ripples from the LSB.
module sub_n #(
    parameter int W = 9
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic [W-1:0] Diff,
    output logic         Bout
);

    logic [W:0] brw;

    assign brw[0] = Bin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign Diff[i]  = A[i] ^ B[i] ^ brw[i];
        // Borrow out when A < B + borrow-in at this bit.
        assign brw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & brw[i]);
    end

    assign Bout = brw[W];

endmodule

// File: rtl/seq_div_8.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit per clock; a zero divisor finishes immediately.
module seq_div_8
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, d_r;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_sh, diff, r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             bout, last, div0;

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign r_sh = {r_r[WIDTH-1:0], q_r[WIDTH-1]};

    sub_n #(.W(WIDTH + 1)) u_sub (
        .A    (r_sh),
        .B    ({1'b0, d_r}),
        .Bin  (1'b0),
        .Diff (diff),
        .Bout (bout)
    );

    assign r_nxt = bout ? r_sh : diff;
    assign q_nxt = {q_r[WIDTH-2:0], ~bout};
    assign last  = (cnt == CW'(1));
    assign div0  = (divisor == '0);
    assign busy  = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !div0) state_nxt = S_RUN;
            S_RUN:   if (last)           state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r         <= '0;
            r_r         <= '0;
            d_r         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (div0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            q_r <= dividend;
                            r_r <= '0;
                            d_r <= divisor;
                            cnt <= CW'(WIDTH);
                        end
                    end
                end
                S_RUN: begin
                    r_r <= r_nxt;
                    q_r <= q_nxt;
                    cnt <= cnt - CW'(1);
                    // Final iteration lands straight in the output registers.
                    if (last) begin
                        quotient    <= q_nxt;
                        remainder   <= r_nxt[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_8.sv
// Directed checks for seq_div_8: latency, results, divide-by-zero, ignored
// starts, mid-run reset, back-to-back issue and a small reference sweep.
module tb_seq_div_8;
    import div_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, start, busy, done, div_by_zero;
    logic [7:0] dividend, divisor, quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_div_8 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Issues one start from a negedge and watches up to 30 cycles; optional
    // second start pulse at cycle 'poke'. Ends on a negedge with start low.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input int poke, input logic [7:0] pa, input logic [7:0] pb,
                          output logic [7:0] q, output logic [7:0] r, output logic z,
                          output int nbusy, output int ndone, output int lat);
        dividend = a; divisor = b; start = 1'b1;
        nbusy = 0; ndone = 0; lat = -1; q = 8'hxx; r = 8'hxx; z = 1'bx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            nbusy += int'(busy);
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = i; q = quotient; r = remainder; z = div_by_zero; end
            end
            if (lat > 0 && i >= lat + 2) break;
            if (i == poke) begin
                start = 1'b1; dividend = pa; divisor = pb;
            end else begin
                start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if ({quotient, remainder} !== 16'h0) begin n_fail++; $display("FAIL reset_results: got %h/%h want 0/0", quotient, remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] q, r; logic z; int nb, nd, lat;
        do_div(8'd200, 8'd7, 0, 8'd0, 8'd0, q, r, z, nb, nd, lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", lat); end
        n_checks++; if (nb != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", nd); end
        n_checks++; if (q !== 8'd28 || r !== 8'd4) begin n_fail++; $display("FAIL basic_200_7: got %0d r %0d want 28 r 4", q, r); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", z); end
    endtask

    task automatic test_edges();
        logic [7:0] va [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
        logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd3, 8'd255};
        logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
        logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0, 8'd0};
        logic [7:0] q, r; logic z; int nb, nd, lat;
        for (int k = 0; k < 4; k++) begin
            do_div(va[k], vb[k], 0, 8'd0, 8'd0, q, r, z, nb, nd, lat);
            n_checks++;
            if (q !== eq[k] || r !== er[k] || lat != 9) begin
                n_fail++;
                $display("FAIL edge_%0d_%0d: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=9", va[k], vb[k], q, r, lat, eq[k], er[k]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic z; int nb, nd, lat;
        do_div(8'd77, 8'd0, 0, 8'd0, 8'd0, q, r, z, nb, nd, lat);
        n_checks++; if (lat != 1 || nd != 1) begin n_fail++; $display("FAIL div0_timing: got lat=%0d dones=%0d want 1/1", lat, nd); end
        n_checks++; if (nb != 0) begin n_fail++; $display("FAIL div0_busy: got %0d busy cycles want 0", nb); end
        n_checks++; if (q !== DIV0_QUOT || r !== 8'd77 || z !== 1'b1) begin n_fail++; $display("FAIL div0_results: got q=%0d r=%0d z=%b want 255 77 1", q, r, z); end
        n_checks++; if (div_by_zero !== 1'b1 || quotient !== 8'd255) begin n_fail++; $display("FAIL div0_hold: got z=%b q=%0d want 1 255", div_by_zero, quotient); end
        do_div(8'd10, 8'd3, 0, 8'd0, 8'd0, q, r, z, nb, nd, lat);
        n_checks++; if (q !== 8'd3 || r !== 8'd1 || z !== 1'b0) begin n_fail++; $display("FAIL div0_clear: got q=%0d r=%0d z=%b want 3 1 0", q, r, z); end
    endtask

    task automatic test_start_busy();
        logic [7:0] q, r; logic z; int nb, nd, lat;
        do_div(8'd200, 8'd7, 3, 8'd9, 8'd2, q, r, z, nb, nd, lat);
        n_checks++; if (q !== 8'd28 || r !== 8'd4) begin n_fail++; $display("FAIL busy_start_result: got %0d r %0d want 28 r 4", q, r); end
        n_checks++; if (nd != 1 || lat != 9 || nb != 8) begin n_fail++; $display("FAIL busy_start_timing: got dones=%0d lat=%0d busy=%0d want 1 9 8", nd, lat, nb); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] q, r; logic z; int nb, nd, lat, ndone;
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d z=%b want all 0", busy, done, quotient, remainder, div_by_zero);
        end
        ndone = 0;
        repeat (15) begin @(negedge clk); ndone += int'(done); end
        n_checks++; if (ndone != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got dones=%0d busy=%b want 0 0", ndone, busy); end
        do_div(8'd100, 8'd10, 0, 8'd0, 8'd0, q, r, z, nb, nd, lat);
        n_checks++; if (q !== 8'd10 || r !== 8'd0 || lat != 9) begin n_fail++; $display("FAIL midreset_fresh: got q=%0d r=%0d lat=%0d want 10 0 9", q, r, lat); end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1;
        logic [7:0] q1 = 8'hxx, r1 = 8'hxx, q2 = 8'hxx, r2 = 8'hxx;
        logic b_after = 1'b0;
        dividend = 8'd50; divisor = 8'd6; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == t1 + 1 && t1 > 0) begin b_after = busy; start = 1'b0; end
            if (done) begin
                if (t1 < 0) begin t1 = i; q1 = quotient; r1 = remainder; dividend = 8'd99; divisor = 8'd8; end
                else if (t2 < 0) begin t2 = i; q2 = quotient; r2 = remainder; end
            end
            if (t2 > 0) break;
        end
        start = 1'b0;
        n_checks++; if (q1 !== 8'd8 || r1 !== 8'd2) begin n_fail++; $display("FAIL b2b_first: got %0d r %0d want 8 r 2", q1, r1); end
        n_checks++; if (b_after !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", b_after); end
        n_checks++; if (t1 < 0 || t2 - t1 != 9) begin n_fail++; $display("FAIL b2b_spacing: got t1=%0d t2=%0d want gap 9", t1, t2); end
        n_checks++; if (q2 !== 8'd12 || r2 !== 8'd3) begin n_fail++; $display("FAIL b2b_second: got %0d r %0d want 12 r 3", q2, r2); end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [7:0] a, b, q, r; logic z; int nb, nd, lat;
        for (int k = 0; k < 12; k++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            if (k < 4) b = 8'($urandom_range(1, 15));
            do_div(a, b, 0, 8'd0, 8'd0, q, r, z, nb, nd, lat);
            n_checks++;
            if (q !== a / b || r !== a % b || z !== 1'b0 || nd != 1) begin
                n_fail++;
                $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d z=%b dones=%0d want q=%0d r=%0d", a, b, q, r, z, nd, a / b, a % b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_start_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
